// File: rtl/switch_reader.sv
// ---------------------------------------------------------------------------
// switch_reader
//
// Memory-mapped input peripheral returning board switch and push-button
// state to the CPU on an IO load. Raw pins are synchronised (two flops),
// debounced per group (switches, buttons), and button presses are latched
// in sticky bits until software reads the button word.
//
// All flops update on the falling edge of clk so that read_data is stable
// for the CPU's following rising-edge writeback.
//
// Ports
//   clk         system clock (state updates on negedge)
//   rst         synchronous active-low reset, sampled on negedge clk
//   SwitchCtrl  IO read select from the memory/IO decoder
//   addr_sel    0: switch word, 1: button word
//   switch_in   raw asynchronous switch pins   [SW_WIDTH-1:0]
//   button_in   raw asynchronous button pins   [BTN_WIDTH-1:0], active-high
//   read_data   32-bit word returned to the CPU; holds between reads
//   btn_irq     (only with SWITCH_READER_IRQ_EN) OR of the sticky bits
//
// Word layout
//   addr_sel=0: {zero pad, debounced switches[SW_WIDTH-1:0]}
//   addr_sel=1: {zero pad, debounced buttons at [BTN_WIDTH+15:16],
//                sticky presses at [BTN_WIDTH-1:0]}
//
// Legal configurations: SW_WIDTH <= 32, BTN_WIDTH <= 16,
// DEBOUNCE_CYCLES >= 2.
//
// Optional feature macro: SWITCH_READER_IRQ_EN adds the btn_irq output.
//
// Handshake: there is no valid/ready pair. A read is a single-cycle strobe:
// SwitchCtrl=1 at a falling edge loads read_data with the selected word
// (built from state before that edge); a button read also clears the
// sticky bits at that same edge. The CPU may sample read_data any time
// after that falling edge until the next read.
// ---------------------------------------------------------------------------
module switch_reader #(
  parameter int SW_WIDTH        = 16,
  parameter int BTN_WIDTH       = 5,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SwitchCtrl,
  input  logic                 addr_sel,
  input  logic [SW_WIDTH-1:0]  switch_in,
  input  logic [BTN_WIDTH-1:0] button_in,
  output logic [31:0]          read_data
`ifdef SWITCH_READER_IRQ_EN
  ,
  output logic                 btn_irq
`endif
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  // Synchroniser chains
  logic [SW_WIDTH-1:0]  sw_s1, sw_s2;
  logic [BTN_WIDTH-1:0] btn_s1, btn_s2;

  // Debounce state
  logic [SW_WIDTH-1:0]  sw_db, sw_db_next;
  logic [CW-1:0]        sw_cnt, sw_cnt_next;
  logic [BTN_WIDTH-1:0] btn_db, btn_db_next;
  logic [CW-1:0]        btn_cnt, btn_cnt_next;

  // Press latch and read path
  logic [BTN_WIDTH-1:0] sticky, sticky_next, btn_rise;
  logic                 btn_read;
  logic [31:0]          sw_word, btn_word, read_next;

  // Switch debounce: the counter only advances while the synced vector
  // differs from the debounced one; any return to equality clears it.
  always_comb begin
    sw_db_next  = sw_db;
    sw_cnt_next = '0;
    if (sw_s2 != sw_db) begin
      if (sw_cnt == CNT_MAX) begin
        sw_db_next = sw_s2;
      end else begin
        sw_cnt_next = sw_cnt + CNT_ONE;
      end
    end
  end

  // Button debounce, same scheme as the switches.
  always_comb begin
    btn_db_next  = btn_db;
    btn_cnt_next = '0;
    if (btn_s2 != btn_db) begin
      if (btn_cnt == CNT_MAX) begin
        btn_db_next = btn_s2;
      end else begin
        btn_cnt_next = btn_cnt + CNT_ONE;
      end
    end
  end

  // Press latch: a debounced 0->1 edge sets the bit at the same edge the
  // debounced value loads. The set is OR-ed after the read clear so a
  // press coinciding with a button read is kept for the next read.
  always_comb begin
    btn_read    = SwitchCtrl & addr_sel;
    btn_rise    = btn_db_next & ~btn_db;
    sticky_next = (btn_read ? '0 : sticky) | btn_rise;
  end

  // Read words are built from the pre-edge state, so a read returns the
  // sticky bits as they were before its own clear.
  always_comb begin
    sw_word                       = '0;
    sw_word[SW_WIDTH-1:0]         = sw_db;
    btn_word                      = '0;
    btn_word[BTN_WIDTH+15:16]     = btn_db;
    btn_word[BTN_WIDTH-1:0]       = sticky;
    read_next                     = read_data;
    if (SwitchCtrl) begin
      read_next = addr_sel ? btn_word : sw_word;
    end
  end

  always_ff @(negedge clk) begin
    if (!rst) begin
      sw_s1     <= '0;
      sw_s2     <= '0;
      btn_s1    <= '0;
      btn_s2    <= '0;
      sw_db     <= '0;
      sw_cnt    <= '0;
      btn_db    <= '0;
      btn_cnt   <= '0;
      sticky    <= '0;
      read_data <= '0;
    end else begin
      sw_s1     <= switch_in;
      sw_s2     <= sw_s1;
      btn_s1    <= button_in;
      btn_s2    <= btn_s1;
      sw_db     <= sw_db_next;
      sw_cnt    <= sw_cnt_next;
      btn_db    <= btn_db_next;
      btn_cnt   <= btn_cnt_next;
      sticky    <= sticky_next;
      read_data <= read_next;
    end
  end

`ifdef SWITCH_READER_IRQ_EN
  // Level interrupt tracking the sticky bits as updated this edge.
  always_ff @(negedge clk) begin
    if (!rst) begin
      btn_irq <= 1'b0;
    end else begin
      btn_irq <= |sticky_next;
    end
  end
`endif

endmodule
